// File: rtl/timer_pkg.sv
// Shared register offsets and state encodings for the DIV/TIMA timer block.
package timer_pkg;

  localparam logic [1:0] DIV_OFS  = 2'd0;
  localparam logic [1:0] TIMA_OFS = 2'd1;
  localparam logic [1:0] TMA_OFS  = 2'd2;
  localparam logic [1:0] TAC_OFS  = 2'd3;

  typedef enum logic [1:0] {
    TAC_256 = 2'b00,
    TAC_4   = 2'b01,
    TAC_16  = 2'b10,
    TAC_64  = 2'b11
  } tac_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } tima_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 14-bit system counter, DIV view, and falling-edge tick detector on the selected tap.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [2:0] tac,
  output logic [7:0] div,
  output logic       tick
);

  logic [13:0] cnt_q, cnt_d;
  logic        sig_q, sig, tap;

  assign cnt_d = clr ? 14'd0 : cnt_q + 14'd1;
  assign div   = cnt_q[13:6];

  always_comb begin
    tap = 1'b0;
    case (tac_sel_t'(tac[1:0]))
      TAC_256: tap = cnt_q[7];
      TAC_4:   tap = cnt_q[1];
      TAC_16:  tap = cnt_q[3];
      TAC_64:  tap = cnt_q[5];
      default: tap = 1'b0;
    endcase
  end

  // Falling edges from DIV clears or TAC rewrites also tick, mirroring DMG hardware.
  assign sig  = tac[2] & tap;
  assign tick = sig_q & ~sig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 14'd0;
      sig_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sig_q <= sig;
    end
  end

endmodule

// File: rtl/timer.sv
// Memory-mapped DIV/TIMA/TMA/TAC timer with overflow reload sequencing and a one-cycle interrupt pulse.
module timer
  import timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_in,
  input  logic        write,
  output logic [7:0]  d_out,
  output logic        sel,
  output logic        irq
);

  tima_state_t state_q, state_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        irq_d;
  logic [15:0] ofs;
  logic [7:0]  div;
  logic        tick;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  // Addresses below BASE_ADDR wrap to large offsets, so one compare covers the window.
  assign ofs = addr - BASE_ADDR;
  assign sel = (ofs < 16'd4);

  assign wr_div  = write & sel & (ofs[1:0] == DIV_OFS);
  assign wr_tima = write & sel & (ofs[1:0] == TIMA_OFS);
  assign wr_tma  = write & sel & (ofs[1:0] == TMA_OFS);
  assign wr_tac  = write & sel & (ofs[1:0] == TAC_OFS);

  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (wr_div),
    .tac  (tac_q),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    d_out = 8'hFF;
    if (sel) begin
      case (ofs[1:0])
        DIV_OFS:  d_out = div;
        TIMA_OFS: d_out = tima_q;
        TMA_OFS:  d_out = tma_q;
        default:  d_out = {5'b11111, tac_q};
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    tima_d  = tima_q;
    tma_d   = wr_tma ? d_in : tma_q;
    tac_d   = wr_tac ? d_in[2:0] : tac_q;
    irq_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (wr_tima) begin
          tima_d = d_in;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_d  = d_in;
          state_d = RUN;
        end else begin
          tima_d  = wr_tma ? d_in : tma_q;
          irq_d   = 1'b1;
          state_d = RELOAD;
        end
      end
      RELOAD: begin
        // TIMA tracks TMA writes here; direct TIMA writes and ticks are dropped.
        if (wr_tma) tima_d = d_in;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      irq     <= 1'b0;
    end else begin
      state_q <= state_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      irq     <= irq_d;
    end
  end

endmodule
